t5_wbarb: RTL and testbench

Two-master to one-slave Wishbone arbiter downstream of the t5 core. It merges the core's instruction port (iwb_*) and data port (dwb_*) onto a single memory bus (mem_*). It uses registered grants, round-robin tie-breaking and a bus-timeout watchdog, so a unified single-port memory can serve the whole CPU.

---
 rtl/t5_pkg.sv | 25 ++
 rtl/t5_wbtmo.sv | 49 ++++
 rtl/t5_wbarb.sv | 166 ++++++++++++++++
 tb/tb_t5_wbarb.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : t5_pkg
//  Description : Shared constants for the t5 Wishbone arbiter: FSM state
//                encoding, bus-owner encoding and watchdog defaults.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package t5_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bus owner encoding (also the encoding of the fairness register)
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  // Watchdog defaults: cycles in GNT without mem_ack before a forced ack
  localparam int unsigned TMO_DEFAULT = 255;
  localparam int unsigned CW_DEFAULT  = 8;

endpackage : t5_pkg
`default_nettype wire

// File: rtl/t5_wbtmo.sv
`default_nettype none
// ============================================================================
//  Module      : t5_wbtmo
//  Description : Saturating bus-timeout counter. Cleared on entry to the
//                grant phase, counts every enabled cycle, and flags expiry
//                on the cycle whose count equals TMO-1. TMO=0 disables it.
//  Ports       : clk    - clock
//                rst    - synchronous active-high reset
//                clr    - clear counter to zero (priority over en)
//                en     - count this cycle (arbiter is in GNT)
//                expire - watchdog fires this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module t5_wbtmo #(
  parameter int unsigned TMO = 255,
  parameter int unsigned CW  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // TMO must be representable in CW bits; the caller guarantees TMO < 2**CW.
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CW{1'b1}})) begin
      // Saturate rather than wrap so a disabled or huge TMO never re-fires.
      cnt <= cnt + 1'b1;
    end
  end

  generate
    if (TMO != 0) begin : g_wdog_on
      // Count starts at 0 in the first GNT cycle, so TMO-1 is the TMO-th cycle.
      assign expire = en && (cnt == CW'(TMO - 1));
    end else begin : g_wdog_off
      assign expire = 1'b0;
    end
  endgenerate

endmodule : t5_wbtmo
`default_nettype wire

// File: rtl/t5_wbarb.sv
`default_nettype none
// ============================================================================
//  Module      : t5_wbarb
//  Description : Two-master (instruction / data) to one-slave Wishbone
//                arbiter. Registered grants, round-robin tie-breaking and a
//                bus-timeout watchdog that terminates a stuck transfer with
//                a zero-data ack plus a tmo_err pulse.
//  Ports       : sys_clk, sys_rst          - clock, sync active-high reset
//                iwb_adr/stb/wre/sel       - instruction master request
//                iwb_dat/ack               - instruction master response
//                dwb_adr/dto/sel/wre/stb   - data master request
//                dwb_dti/ack               - data master response
//                mem_adr/dto/sel/wre/stb   - shared memory bus request
//                mem_dti/ack               - shared memory bus response
//                tmo_err                   - one-cycle watchdog pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module t5_wbarb
  import t5_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEFAULT,
  parameter int unsigned CW  = CW_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  // instruction master
  input  logic [31:2] iwb_adr,
  input  logic        iwb_stb,
  input  logic        iwb_wre,
  input  logic [3:0]  iwb_sel,
  output logic [31:0] iwb_dat,
  output logic        iwb_ack,
  // data master
  input  logic [31:2] dwb_adr,
  input  logic [31:0] dwb_dto,
  input  logic [3:0]  dwb_sel,
  input  logic        dwb_wre,
  input  logic        dwb_stb,
  output logic [31:0] dwb_dti,
  output logic        dwb_ack,
  // memory slave
  output logic [31:2] mem_adr,
  output logic [31:0] mem_dto,
  output logic [3:0]  mem_sel,
  output logic        mem_wre,
  output logic        mem_stb,
  input  logic [31:0] mem_dti,
  input  logic        mem_ack,
  // watchdog
  output logic        tmo_err
);

  logic [1:0]  state;
  logic        own;        // master currently holding the bus
  logic        last;       // master served most recently
  logic        req_any;
  logic        grant_sel;  // owner chosen if a grant happens this cycle
  logic        xfer_end;   // GNT terminates this cycle (ack or timeout)
  logic        tmo_expire;
  logic [31:0] rd_data;

  // --------------------------------------------------------------------------
  // Grant selection: a lone requester wins; on a tie the master that was not
  // served last wins, so continuous contention alternates I, D, I, D.
  // --------------------------------------------------------------------------
  always_comb begin
    req_any = iwb_stb | dwb_stb;
    if (iwb_stb && dwb_stb) begin
      grant_sel = (last == OWN_I) ? OWN_D : OWN_I;
    end else if (dwb_stb) begin
      grant_sel = OWN_D;
    end else begin
      grant_sel = OWN_I;
    end
  end

  // A real ack always wins over a watchdog expiry in the same cycle.
  assign xfer_end = (state == ST_GNT) && (mem_ack || tmo_expire);
  assign rd_data  = mem_ack ? mem_dti : 32'h0;

  t5_wbtmo #(
    .TMO (TMO),
    .CW  (CW)
  ) u_tmo (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clr    ((state == ST_IDLE) && req_any),
    .en     (state == ST_GNT),
    .expire (tmo_expire)
  );

  // --------------------------------------------------------------------------
  // Arbiter FSM and all registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= ST_IDLE;
      own     <= OWN_I;
      last    <= OWN_D;     // makes I win the first tie after reset
      mem_adr <= '0;
      mem_dto <= '0;
      mem_sel <= '0;
      mem_wre <= 1'b0;
      mem_stb <= 1'b0;
      iwb_dat <= '0;
      iwb_ack <= 1'b0;
      dwb_dti <= '0;
      dwb_ack <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      // Acks and the watchdog flag are single-cycle pulses.
      iwb_ack <= 1'b0;
      dwb_ack <= 1'b0;
      tmo_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req_any) begin
            own     <= grant_sel;
            mem_stb <= 1'b1;
            state   <= ST_GNT;
            if (grant_sel == OWN_D) begin
              mem_adr <= dwb_adr;
              mem_sel <= dwb_sel;
              mem_wre <= dwb_wre;
              mem_dto <= dwb_dto;
            end else begin
              mem_adr <= iwb_adr;
              mem_sel <= iwb_sel;
              mem_wre <= iwb_wre;
              mem_dto <= 32'h0;   // instruction port has no write data
            end
          end
        end

        ST_GNT: begin
          // Request fields stay latched; master-side changes are ignored here.
          if (xfer_end) begin
            if (own == OWN_D) begin
              dwb_dti <= rd_data;
              dwb_ack <= 1'b1;
            end else begin
              iwb_dat <= rd_data;
              iwb_ack <= 1'b1;
            end
            tmo_err <= ~mem_ack;
            mem_stb <= 1'b0;
            last    <= own;
            state   <= ST_DONE;
          end
        end

        ST_DONE: begin
          // The acked master still shows stb this cycle; do not re-grant it.
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : t5_wbarb
`default_nettype wire

// File: tb/tb_t5_wbarb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_t5_wbarb
//  Description : Scoreboard bench for t5_wbarb. Stimulus predicts each
//                transfer (grant order, latched fields, data, latency,
//                timeout) and queues it; a monitor compares what the DUT
//                presents on the memory bus and the master acks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_t5_wbarb;

  localparam int TMO = 8;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [31:2] iwb_adr = '0;
  logic        iwb_stb = 1'b0;
  logic        iwb_wre = 1'b0;
  logic [3:0]  iwb_sel = '0;
  logic [31:0] iwb_dat;
  logic        iwb_ack;
  logic [31:2] dwb_adr = '0;
  logic [31:0] dwb_dto = '0;
  logic [3:0]  dwb_sel = '0;
  logic        dwb_wre = 1'b0;
  logic        dwb_stb = 1'b0;
  logic [31:0] dwb_dti;
  logic        dwb_ack;
  logic [31:2] mem_adr;
  logic [31:0] mem_dto;
  logic [3:0]  mem_sel;
  logic        mem_wre;
  logic        mem_stb;
  logic [31:0] mem_dti = '0;
  logic        mem_ack = 1'b0;
  logic        tmo_err;

  t5_wbarb #(.TMO(TMO), .CW(8)) dut (
    .sys_clk (sys_clk), .sys_rst (sys_rst),
    .iwb_adr (iwb_adr), .iwb_stb (iwb_stb), .iwb_wre (iwb_wre),
    .iwb_sel (iwb_sel), .iwb_dat (iwb_dat), .iwb_ack (iwb_ack),
    .dwb_adr (dwb_adr), .dwb_dto (dwb_dto), .dwb_sel (dwb_sel),
    .dwb_wre (dwb_wre), .dwb_stb (dwb_stb), .dwb_dti (dwb_dti),
    .dwb_ack (dwb_ack),
    .mem_adr (mem_adr), .mem_dto (mem_dto), .mem_sel (mem_sel),
    .mem_wre (mem_wre), .mem_stb (mem_stb), .mem_dti (mem_dti),
    .mem_ack (mem_ack), .tmo_err (tmo_err)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=no_event (cycle %0d)", name, cyc);
  endtask

  // Expected transfer as seen on the shared bus and at the master ack.
  typedef struct {
    bit          own;    // 0 = I, 1 = D
    logic [29:0] adr;
    logic [3:0]  sel;
    bit          wre;
    logic [31:0] dto;
    logic [31:0] rdat;
    bit          tmo;
    int          lat;    // cycles from mem_stb rise to ack
    bit          first;  // first transfer of a round (stb raised from idle)
    int          issue;  // cycle in which the request was raised
  } exp_t;

  typedef struct {
    int          w;      // wait cycles before slave acks
    logic [31:0] d;
  } sl_t;

  exp_t exp_q[$];
  sl_t  sl_q[$];
  bit   mdl_last = 1'b1;          // last-served master as the model sees it
  logic [31:0] mdl_idat = '0;
  logic [31:0] mdl_ddat = '0;
  int   wtab [8];

  // --------------------------------------------------------------------------
  // Slave: acks after the queued number of wait cycles; when not selected it
  // throws stray acks and junk data that the arbiter must ignore.
  // --------------------------------------------------------------------------
  initial begin
    bit  busy = 0;
    int  n = 0;
    sl_t s;
    s.w = 0;
    s.d = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (mem_stb !== 1'b1) begin
        busy    = 0;
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_dti = $urandom;
      end else begin
        if (!busy) begin
          busy = 1;
          n    = 0;
          if (sl_q.size() == 0) begin
            fail_now("slave_queue_empty");
            s.w = 0;
            s.d = '0;
          end else begin
            s = sl_q.pop_front();
          end
        end
        mem_ack = (n == s.w);
        mem_dti = (n == s.w) ? s.d : $urandom;
        n++;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin
    bit   active   = 0;
    bit   rst_flag = 0;
    exp_t cur;
    int   rise_cyc = 0;
    int   ack_cyc  = -100;
    cur = '{default: '0};
    forever begin
      @(negedge sys_clk);
      if (rst_flag) begin
        check("rst_ctl", 64'({mem_stb, mem_wre, iwb_ack, dwb_ack, tmo_err, mem_sel}), 64'd0);
        check("rst_adr", 64'(mem_adr), 64'd0);
        check("rst_dto", 64'(mem_dto), 64'd0);
        check("rst_rdat", {iwb_dat, dwb_dti}, 64'd0);
      end
      rst_flag = sys_rst;
      if (sys_rst) begin
        active   = 0;
        mdl_idat = '0;
        mdl_ddat = '0;
        exp_q.delete();
        continue;
      end

      if (!active && mem_stb) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_grant");
        end else begin
          cur      = exp_q.pop_front();
          active   = 1;
          rise_cyc = cyc;
          check("grant_adr", 64'(mem_adr), 64'(cur.adr));
          check("grant_sel_wre", 64'({mem_sel, mem_wre}), 64'({cur.sel, cur.wre}));
          check("grant_dto", 64'(mem_dto), 64'(cur.dto));
          if (cur.first) check("grant_latency", 64'(cyc - cur.issue), 64'd1);
          else           check("b2b_gap", 64'(cyc - ack_cyc), 64'd2);
        end
      end else if (active && mem_stb) begin
        check("hold_fields", 64'({mem_adr, mem_sel, mem_wre}), 64'({cur.adr, cur.sel, cur.wre}));
        check("hold_dto", 64'(mem_dto), 64'(cur.dto));
      end

      if (iwb_ack || dwb_ack) begin
        if (!active) begin
          fail_now("spurious_ack");
        end else begin
          check("ack_master", 64'({iwb_ack, dwb_ack}), cur.own ? 64'd1 : 64'd2);
          check("ack_tmo_stb", 64'({tmo_err, mem_stb}), 64'({cur.tmo, 1'b0}));
          check("ack_latency", 64'(cyc - rise_cyc), 64'(cur.lat));
          if (cur.own) mdl_ddat = cur.rdat;
          else         mdl_idat = cur.rdat;
          check("iwb_dat", 64'(iwb_dat), 64'(mdl_idat));
          check("dwb_dti", 64'(dwb_dti), 64'(mdl_ddat));
          active  = 0;
          ack_cyc = cyc;
        end
      end else begin
        if (tmo_err) fail_now("tmo_err_without_ack");
        if (active && !mem_stb) fail_now("stb_dropped_without_ack");
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus. Always entered and left at posedge+1.
  // --------------------------------------------------------------------------
  task automatic round(input bit ri, input bit rd, input int wi, input int wd,
                       input logic [29:0] ai, input logic [3:0] si, input bit wri,
                       input logic [29:0] ad, input logic [3:0] sd, input bit wrd,
                       input logic [31:0] dto, input logic [31:0] di, input logic [31:0] dd);
    bit   ord [2];
    int   nt;
    int   phase;
    exp_t e;
    sl_t  s;
    nt     = (ri && rd) ? 2 : 1;
    ord[0] = (ri && rd) ? ~mdl_last : rd;
    ord[1] = ~ord[0];
    for (int k = 0; k < nt; k++) begin
      e.own   = ord[k];
      e.adr   = ord[k] ? ad : ai;
      e.sel   = ord[k] ? sd : si;
      e.wre   = ord[k] ? wrd : wri;
      e.dto   = ord[k] ? dto : 32'h0;
      s.w     = ord[k] ? wd : wi;
      s.d     = ord[k] ? dd : di;
      e.tmo   = (s.w >= TMO);
      e.rdat  = e.tmo ? 32'h0 : s.d;
      e.lat   = e.tmo ? TMO : s.w + 1;
      e.first = (k == 0);
      e.issue = cyc;
      exp_q.push_back(e);
      sl_q.push_back(s);
      mdl_last = ord[k];
    end
    iwb_adr = ai; iwb_sel = si; iwb_wre = wri; iwb_stb = ri;
    dwb_adr = ad; dwb_sel = sd; dwb_wre = wrd; dwb_dto = dto; dwb_stb = rd;
    phase = 0;
    for (int t = 0; t < 80 && phase < nt; t++) begin
      @(posedge sys_clk);
      #1;
      if ((ord[phase] == 1'b0) ? iwb_ack : dwb_ack) begin
        if (ord[phase]) dwb_stb = 1'b0;
        else            iwb_stb = 1'b0;
        phase++;
      end else if (mem_stb) begin
        // Owner keeps stb but wiggles its fields; the bus must not follow.
        if (ord[phase]) begin
          dwb_adr = 30'($urandom); dwb_sel = 4'($urandom); dwb_dto = $urandom;
        end else begin
          iwb_adr = 30'($urandom); iwb_sel = 4'($urandom);
        end
      end
    end
    if (phase < nt) fail_now("round_timeout");
    iwb_stb = 1'b0;
    dwb_stb = 1'b0;
    repeat (1 + $urandom_range(0, 2)) @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_mid_transfer();
    exp_t e;
    sl_t  s;
    e.own = 1'b1; e.adr = 30'h3A5; e.sel = 4'hF; e.wre = 1'b0;
    e.dto = 32'h1234_5678; e.rdat = 32'hBAD0_BAD0; e.tmo = 1'b0;
    e.lat = 5; e.first = 1'b1; e.issue = cyc;
    s.w = 4; s.d = 32'hBAD0_BAD0;
    exp_q.push_back(e);
    sl_q.push_back(s);
    dwb_adr = e.adr; dwb_sel = e.sel; dwb_wre = e.wre; dwb_dto = e.dto; dwb_stb = 1'b1;
    @(posedge sys_clk); #1;          // cycle 1: granted
    @(posedge sys_clk); #1;          // cycle 2: reset
    sys_rst  = 1'b1;
    dwb_stb  = 1'b0;
    mdl_last = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    repeat (12) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    bit ri, rd;
    wtab = '{0, 1, 2, 3, 4, 7, 8, 20};
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;

    // Instruction read, zero-wait
    round(1, 0, 0, 0, 30'h100, 4'hF, 0, 30'h0, 4'h0, 0, 32'h0, 32'h0000_0013, 32'h0);
    // Data write, zero-wait
    round(0, 1, 0, 0, 30'h0, 4'h0, 0, 30'h200, 4'b0011, 1, 32'hDEAD_BEEF, 32'h0, 32'h0BAD_F00D);
    // Contention after reset: I, D, I, D, ...
    for (int k = 0; k < 3; k++)
      round(1, 1, 0, 0, 30'($urandom), 4'($urandom), 0, 30'($urandom), 4'($urandom),
            1'($urandom), $urandom, $urandom, $urandom);
    // Four wait states with master-side changes during GNT
    round(0, 1, 0, 4, 30'h0, 4'h0, 0, 30'h2C0, 4'hF, 1, 32'hCAFE_0001, 32'h0, 32'h5555_AAAA);
    // Watchdog: slave never acks, then a normal request
    round(0, 1, 0, 20, 30'h0, 4'h0, 0, 30'h300, 4'hF, 0, 32'h0, 32'h0, 32'hFFFF_FFFF);
    round(1, 0, 1, 0, 30'h104, 4'hF, 0, 30'h0, 4'h0, 0, 32'h0, 32'h0000_0093, 32'h0);
    // Reset in the middle of a 4-wait transfer, then contention again
    reset_mid_transfer();
    round(1, 1, 0, 2, 30'h10, 4'hF, 0, 30'h20, 4'h1, 1, 32'h7777_0000, 32'h11, 32'h22);

    for (int r = 0; r < 60; r++) begin
      int m;
      m  = $urandom_range(0, 2);
      ri = (m != 1);
      rd = (m != 0);
      round(ri, rd, wtab[$urandom_range(0, 7)], wtab[$urandom_range(0, 7)],
            30'($urandom), 4'($urandom), 1'($urandom),
            30'($urandom), 4'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom);
    end

    repeat (5) @(posedge sys_clk);
    #1;
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    check("slave_queue_drained", 64'(sl_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_t5_wbarb
`default_nettype wire
